// File: rtl/lif_pkg.sv
// ----------------------------------------------------------------------------
// lif_pkg
// Shared constants and helpers for the LIF neuron array.
//   LIF_RST_ZERO / LIF_RST_SUB : RESET_MODE encodings
//   LIF_REFC_W                 : refractory counter width
//   lif_saturate()             : clamp a WIDTH+2 bit sum to WIDTH bits
// ----------------------------------------------------------------------------
package lif_pkg;

    localparam int unsigned LIF_RST_ZERO = 0;
    localparam int unsigned LIF_RST_SUB  = 1;

    localparam int unsigned LIF_REFC_W   = 4;
    localparam int unsigned LIF_REFC_MAX = (1 << LIF_REFC_W) - 1;

    // Widest supported potential; callers sign-extend into the wide argument
    localparam int unsigned LIF_MAX_W    = 64;
    localparam int unsigned LIF_SAT_IW   = LIF_MAX_W + 2;

    // Clamp x into the signed range of a w-bit value
    function automatic logic signed [LIF_MAX_W-1:0] lif_saturate(
        input logic signed [LIF_SAT_IW-1:0] x,
        input int unsigned                  w
    );
        logic signed [LIF_SAT_IW-1:0] hi;
        logic signed [LIF_SAT_IW-1:0] lo;
        logic signed [LIF_SAT_IW-1:0] res;
        hi = (LIF_SAT_IW'(1) <<< (w - 1)) - LIF_SAT_IW'(1);
        lo = ~hi;
        if (x > hi) begin
            res = hi;
        end else if (x < lo) begin
            res = lo;
        end else begin
            res = x;
        end
        return LIF_MAX_W'(res);
    endfunction

endpackage

// File: rtl/lif_neuron_array_if.sv
// ----------------------------------------------------------------------------
// lif_neuron_array_if
// Step/current bus into the neuron bank and spike/potential bus out of it.
//   step_valid    : one-cycle timestep pulse (master -> slave)
//   in_current    : packed signed lane currents (master -> slave)
//   clear         : soft clear of all lanes (master -> slave)
//   spike_out     : spike vector of the last step (slave -> master)
//   out_valid     : one-cycle pulse with a new spike_out (slave -> master)
//   potential_out : packed signed lane potentials (slave -> master)
// ----------------------------------------------------------------------------
interface lif_neuron_array_if #(
    parameter int unsigned NUM_NEURONS = 8,
    parameter int unsigned WIDTH       = 16
);
    logic                         step_valid;
    logic [NUM_NEURONS*WIDTH-1:0] in_current;
    logic                         clear;
    logic [NUM_NEURONS-1:0]       spike_out;
    logic                         out_valid;
    logic [NUM_NEURONS*WIDTH-1:0] potential_out;

    modport master (
        output step_valid, in_current, clear,
        input  spike_out, out_valid, potential_out
    );

    modport slave (
        input  step_valid, in_current, clear,
        output spike_out, out_valid, potential_out
    );
endinterface

// File: rtl/lif_lane.sv
// ----------------------------------------------------------------------------
// lif_lane
// One leaky integrate-and-fire neuron: leak, integrate with saturation,
// same-step threshold compare, reset/subtract on fire, optional refractory.
// Optional feature macro: LIF_REFRACTORY_EN (per-lane refractory counter).
//   i_clk       : clock
//   i_clr       : synchronous clear (reset or soft clear), highest priority
//   i_step      : advance one timestep
//   i_current   : signed input current
//   o_spike     : registered spike of the last step
//   o_potential : registered signed potential
// ----------------------------------------------------------------------------
module lif_lane
    import lif_pkg::*;
#(
    parameter int unsigned             WIDTH            = 16,
    parameter int unsigned             LEAK_SHIFT       = 1,
    parameter logic signed [WIDTH-1:0] THRESHOLD        = 16'sd1000,
    parameter int unsigned             RESET_MODE       = LIF_RST_ZERO,
    parameter int unsigned             REFRACTORY_STEPS = 2
) (
    input  logic                    i_clk,
    input  logic                    i_clr,
    input  logic                    i_step,
    input  logic signed [WIDTH-1:0] i_current,
    output logic                    o_spike,
    output logic signed [WIDTH-1:0] o_potential
);

    localparam int unsigned EW = WIDTH + 2;

    if (REFRACTORY_STEPS > LIF_REFC_MAX) begin : g_refc_range_err
        $error("REFRACTORY_STEPS does not fit the refractory counter");
    end

    logic signed [WIDTH-1:0] r_p;
    logic                    r_spike;

    logic signed [EW-1:0]    w_p_ext;
    logic signed [EW-1:0]    w_i_ext;
    logic signed [EW-1:0]    w_leaked;
    logic signed [EW-1:0]    w_sum;
    logic signed [WIDTH-1:0] w_sat;
    logic signed [WIDTH-1:0] w_p_fire;
    logic                    w_fire_raw;
    logic                    w_fire;
    logic                    w_hold;

    // Datapath in WIDTH+2 bits so leak + current cannot wrap before clamping
    assign w_p_ext    = EW'(r_p);
    assign w_i_ext    = EW'(i_current);
    assign w_leaked   = w_p_ext - (w_p_ext >>> LEAK_SHIFT);
    assign w_sum      = w_leaked + w_i_ext;
    assign w_sat      = WIDTH'(lif_saturate(LIF_SAT_IW'(w_sum), WIDTH));
    assign w_fire_raw = (w_sat >= THRESHOLD);

    // Post-spike potential; sat >= THRESHOLD > 0 so the subtraction is safe
    always_comb begin
        w_p_fire = '0;
        if (RESET_MODE == LIF_RST_SUB) begin
            w_p_fire = w_sat - THRESHOLD;
        end
    end

`ifdef LIF_REFRACTORY_EN
    logic [LIF_REFC_W-1:0] r_refc;

    assign w_hold = (r_refc != '0);

    // Refractory countdown, reloaded on every spike
    always_ff @(posedge i_clk) begin
        if (i_clr) begin
            r_refc <= '0;
        end else if (i_step) begin
            if (w_hold) begin
                r_refc <= r_refc - LIF_REFC_W'(1);
            end else if (w_fire_raw) begin
                r_refc <= LIF_REFC_W'(REFRACTORY_STEPS);
            end
        end
    end
`else
    assign w_hold = 1'b0;
`endif

    assign w_fire = w_fire_raw & ~w_hold;

    // Potential and spike registers; a held lane keeps P with no leak
    always_ff @(posedge i_clk) begin
        if (i_clr) begin
            r_p     <= '0;
            r_spike <= 1'b0;
        end else if (i_step) begin
            r_spike <= w_fire;
            if (w_hold) begin
                r_p <= r_p;
            end else if (w_fire) begin
                r_p <= w_p_fire;
            end else begin
                r_p <= w_sat;
            end
        end
    end

    assign o_spike     = r_spike;
    assign o_potential = r_p;

endmodule

// File: rtl/lif_neuron_array.sv
// ----------------------------------------------------------------------------
// lif_neuron_array
// Bank of NUM_NEURONS LIF lanes advanced together on each step_valid pulse.
// Optional feature macro: LIF_REFRACTORY_EN (refractory hold after a spike).
//   i_clk : clock, rising edge
//   i_rst : synchronous active-high reset, same effect as clear
//   bus   : lif_neuron_array_if slave (step_valid, in_current, clear in;
//           spike_out, out_valid, potential_out out)
// ----------------------------------------------------------------------------
module lif_neuron_array
    import lif_pkg::*;
#(
    parameter int unsigned             NUM_NEURONS      = 8,
    parameter int unsigned             WIDTH            = 16,
    parameter int unsigned             LEAK_SHIFT       = 1,
    parameter logic signed [WIDTH-1:0] THRESHOLD        = 16'sd1000,
    parameter int unsigned             RESET_MODE       = LIF_RST_ZERO,
    parameter int unsigned             REFRACTORY_STEPS = 2
) (
    input  logic               i_clk,
    input  logic               i_rst,
    lif_neuron_array_if.slave  bus
);

    logic                         w_clr;
    logic                         r_out_valid;
    logic [NUM_NEURONS-1:0]       w_spike;
    logic [NUM_NEURONS*WIDTH-1:0] w_pot;

    // Reset and soft clear both wipe state and drop any same-cycle step
    assign w_clr = i_rst | bus.clear;

    for (genvar g = 0; g < NUM_NEURONS; g++) begin : g_lane
        lif_lane #(
            .WIDTH            (WIDTH),
            .LEAK_SHIFT       (LEAK_SHIFT),
            .THRESHOLD        (THRESHOLD),
            .RESET_MODE       (RESET_MODE),
            .REFRACTORY_STEPS (REFRACTORY_STEPS)
        ) u_lane (
            .i_clk       (i_clk),
            .i_clr       (w_clr),
            .i_step      (bus.step_valid),
            .i_current   (bus.in_current[g*WIDTH +: WIDTH]),
            .o_spike     (w_spike[g]),
            .o_potential (w_pot[g*WIDTH +: WIDTH])
        );
    end

    // One-cycle valid for every accepted step
    always_ff @(posedge i_clk) begin
        if (w_clr) begin
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= bus.step_valid;
        end
    end

    assign bus.out_valid     = r_out_valid;
    assign bus.spike_out     = w_spike;
    assign bus.potential_out = w_pot;

endmodule
